bram_fifo: RTL

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo
//  Description : Synchronous FIFO that stores words in an external 4 kb
//                dual-ported BRAM. A two-slot output stage (head + skid)
//                gives first-word fall-through and one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = $clog2(4096 / DATA_SZ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_full,
    input  logic               i_rd,
    output logic [DATA_SZ-1:0] o_data,
    output logic               o_empty,
    output logic [ADDR_SZ:0]   o_count,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata
);

    localparam logic [ADDR_SZ:0]   DEPTH   = {1'b1, {ADDR_SZ{1'b0}}};
    localparam logic [ADDR_SZ:0]   CNT_ONE = {{ADDR_SZ{1'b0}}, 1'b1};
    localparam logic [ADDR_SZ-1:0] PTR_ONE = {{(ADDR_SZ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ADDR_SZ-1:0]   wptr;
    logic [ADDR_SZ-1:0]   rptr;
    logic [ADDR_SZ:0]     count;
    logic [ADDR_SZ:0]     bram_cnt;     // words in BRAM written in earlier cycles, not yet fetched
    logic                 inflight;     // fetch issued last cycle, data on i_rdata now
    logic [DATA_SZ-1:0]   head;
    logic [DATA_SZ-1:0]   skid;
    logic [1:0]           used;
    logic                 push;
    logic                 pop;
    logic                 fetch;
    logic                 load_head;

    // Acceptance, fetch decision and BRAM port drive from pre-edge state
    always_comb begin
        used = 2'd0;
        case (state)
            ST_ONE:  used = 2'd1;
            ST_TWO:  used = 2'd2;
            default: used = 2'd0;
        endcase
        push = i_wr && !o_full && !i_rst;
        pop  = i_rd && !o_empty;
        // A slot vacated by this cycle's pop is free by the time a new
        // fetch lands, which is what keeps back-to-back pops bubble-free.
        fetch = (bram_cnt != '0) &&
                (({1'b0, used} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
        // Returning data goes straight to head when head is free or leaving.
        load_head = inflight && ((state == ST_EMPTY) || ((state == ST_ONE) && pop));
    end

    assign o_full  = (count == DEPTH);
    assign o_empty = (state == ST_EMPTY);
    assign o_count = count;
    assign o_data  = head;
    assign o_wr_en = push;
    assign o_waddr = wptr;
    assign o_wdata = i_data;
    assign o_rd_en = fetch;
    assign o_raddr = rptr;

    // Pointers, occupancy counters and in-flight flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            bram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fetch;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (fetch) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (push && !fetch) begin
                bram_cnt <= bram_cnt + CNT_ONE;
            end else if (fetch && !push) begin
                bram_cnt <= bram_cnt - CNT_ONE;
            end
        end
    end

    // Output-stage data: capture returning BRAM data, advance skid on pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (inflight) begin
                if (load_head) begin
                    head <= i_rdata;
                end else begin
                    skid <= i_rdata;
                end
            end
            if (pop && (state == ST_TWO)) begin
                head <= skid;
            end
        end
    end

    // Output-stage state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Output-stage next-state: capture fills a slot, pop frees one
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: begin
                if (inflight) begin
                    next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (inflight && !pop) begin
                    next_state = ST_TWO;
                end else if (pop && !inflight) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop && !inflight) begin
                    next_state = ST_ONE;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

endmodule
`default_nettype wire
